// File: rtl/adc_fifo_pkg.sv
// adc_fifo_pkg: shared defaults, clog2 helper and the default-width entry
// layout for the ADC sample FIFO.
package adc_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_CH_WIDTH   = 2;
    localparam int DEF_DEPTH      = 256;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One FIFO entry at the default widths: channel tag above the sample.
    typedef struct packed {
        logic [DEF_CH_WIDTH-1:0]   ch;
        logic [DEF_DATA_WIDTH-1:0] data;
    } adc_entry_t;

endpackage

// File: rtl/adc_fifo_ram.sv
// adc_fifo_ram: simple dual-port storage, one synchronous write port and one
// asynchronous read port, so the FIFO head is visible without a read cycle.
// Contents are deliberately not reset.
module adc_fifo_ram #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adc_stream_fifo.sv
// adc_stream_fifo: single-clock first-word-fall-through FIFO for tagged ADC
// samples. The ADC never stalls, so a write into a full FIFO is dropped and
// counted. Define ADC_FIFO_OVERWRITE_EN to instead overwrite the oldest
// entry on a drop (overflow stats still update).
module adc_stream_fifo
    import adc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CH_WIDTH   = DEF_CH_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = 192,
    parameter int AE_THRESH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      s_valid,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic [CH_WIDTH-1:0]       s_ch,
    output logic                      s_ready,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [CH_WIDTH-1:0]       m_ch,
    output logic [clog2(DEPTH):0]     level,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      ovf_sticky,
    output logic [CNT_WIDTH-1:0]      ovf_cnt,
    input  logic                      ovf_clr
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_THRESH);

    typedef struct packed {
        logic [CH_WIDTH-1:0]   ch;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic                 af_q, af_d, ae_q, ae_d, sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pop, push, drop, we;
    entry_t               wr_entry, rd_entry;

    // Per-cycle events; flush suppresses all of them for its cycle.
    always_comb begin
        pop  = !empty_q & m_ready & !flush;
        push = s_valid & (!full_q | pop) & !flush;
        drop = s_valid & full_q & !pop & !flush;
    end

    // Pointer update and flags computed from next-state pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we       = push;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef ADC_FIFO_OVERWRITE_EN
            // Full and no pop: write slot equals head slot, so both advance
            // and the oldest entry is replaced.
            if (drop) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
`endif
        end
        level_d = wr_ptr_d - rd_ptr_d;
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
        af_d    = (level_d >= LVL_AF);
        ae_d    = (level_d <= LVL_AE);
    end

    // Overflow stats: clear first so a same-cycle drop still registers as one.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (ovf_clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (drop) begin
            sticky_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_entry = '{ch: s_ch, data: s_data};

    adc_fifo_ram #(
        .WIDTH  ($bits(entry_t)),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    assign s_ready      = !full_q;
    assign m_valid      = !empty_q;
    assign m_data       = rd_entry.data;
    assign m_ch         = rd_entry.ch;
    assign level        = level_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign ovf_sticky   = sticky_q;
    assign ovf_cnt      = cnt_q;

endmodule

// File: tb/tb_adc_stream_fifo.sv
// tb_adc_stream_fifo: directed vector table plus hand-written sequences for
// fill/overflow, full pass-through, saturation, flush and async reset.
module tb_adc_stream_fifo;

    localparam int DW    = 12;
    localparam int CW    = 2;
    localparam int DEPTH = 256;
    localparam int CNTW  = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [CW-1:0] s_ch, m_ch;
    logic [8:0]    level;
    logic          full, empty, almost_full, almost_empty, ovf_sticky, ovf_clr;
    logic [CNTW-1:0] ovf_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [DW+CW-1:0] q[$];   // model contents, {ch, data}

    always #5 clk = ~clk;

    adc_stream_fifo #(.CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ch(s_ch), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
        .level(level), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; s_valid = 0; s_data = '0; s_ch = '0; m_ready = 0; ovf_clr = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0;
        idle();
        q.delete();
        #3;
        rst_n = 1;
    endtask

    // Push one sample with no pop; model applies drop or overwrite policy.
    task automatic push_one(input logic [DW-1:0] d, input logic [CW-1:0] c);
        s_valid = 1; s_data = d; s_ch = c; m_ready = 0;
        step();
        s_valid = 0;
        if (q.size() < DEPTH) q.push_back({c, d});
`ifdef ADC_FIFO_OVERWRITE_EN
        else begin
            void'(q.pop_front());
            q.push_back({c, d});
        end
`endif
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          mr;
        int            lvl;
        logic          mv;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t tv[10];
    logic [DW-1:0] exp_head;

    initial begin
        tv[0] = '{1'b1, 12'h001, 2'd0, 1'b0, 1, 1'b1, 12'h001, 2'd0};
        tv[1] = '{1'b1, 12'h002, 2'd1, 1'b0, 2, 1'b1, 12'h001, 2'd0};
        tv[2] = '{1'b1, 12'h003, 2'd2, 1'b0, 3, 1'b1, 12'h001, 2'd0};
        tv[3] = '{1'b0, 12'h000, 2'd0, 1'b1, 2, 1'b1, 12'h002, 2'd1};
        tv[4] = '{1'b0, 12'h000, 2'd0, 1'b1, 1, 1'b1, 12'h003, 2'd2};
        tv[5] = '{1'b0, 12'h000, 2'd0, 1'b1, 0, 1'b0, 12'h000, 2'd0};
        tv[6] = '{1'b1, 12'h0AA, 2'd3, 1'b1, 1, 1'b1, 12'h0AA, 2'd3};
        tv[7] = '{1'b1, 12'h0BB, 2'd1, 1'b1, 1, 1'b1, 12'h0BB, 2'd1};
        tv[8] = '{1'b0, 12'h000, 2'd0, 1'b0, 1, 1'b1, 12'h0BB, 2'd1};
        tv[9] = '{1'b0, 12'h000, 2'd0, 1'b1, 0, 1'b0, 12'h000, 2'd0};

        rst_n = 0;
        idle();
        #12;
        // Reset state
        chk("rst.level", 32'(level), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.m_valid", 32'(m_valid), 0);
        chk("rst.ae", 32'(almost_empty), 1);
        chk("rst.af", 32'(almost_full), 0);
        chk("rst.sticky", 32'(ovf_sticky), 0);
        chk("rst.cnt", 32'(ovf_cnt), 0);
        rst_n = 1;

        // Basic ordering, FWFT latency, push/pop on empty and non-empty
        for (int i = 0; i < 10; i++) begin
            s_valid = tv[i].sv; s_data = tv[i].d; s_ch = tv[i].c; m_ready = tv[i].mr;
            step();
            chk($sformatf("v%0d.level", i), 32'(level), 32'(tv[i].lvl));
            chk($sformatf("v%0d.m_valid", i), 32'(m_valid), 32'(tv[i].mv));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(tv[i].lvl == 0));
            if (tv[i].mv) begin
                chk($sformatf("v%0d.m_data", i), 32'(m_data), 32'(tv[i].ed));
                chk($sformatf("v%0d.m_ch", i), 32'(m_ch), 32'(tv[i].ec));
            end
        end
        idle();

        // Fill to full, watching threshold crossings
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_one(DW'(i), CW'(i));
            if (i + 1 == 16)  chk("fill.ae@16", 32'(almost_empty), 1);
            if (i + 1 == 17)  chk("fill.ae@17", 32'(almost_empty), 0);
            if (i + 1 == 191) chk("fill.af@191", 32'(almost_full), 0);
            if (i + 1 == 192) chk("fill.af@192", 32'(almost_full), 1);
        end
        chk("fill.full", 32'(full), 1);
        chk("fill.s_ready", 32'(s_ready), 0);
        chk("fill.level", 32'(level), 256);
        chk("fill.sticky0", 32'(ovf_sticky), 0);

        // Four writes into a full FIFO
        for (int k = 0; k < 4; k++) push_one(DW'(256 + k), CW'(k));
`ifdef ADC_FIFO_OVERWRITE_EN
        exp_head = 12'd4;
`else
        exp_head = 12'd0;
`endif
        chk("ovf.cnt", 32'(ovf_cnt), 4);
        chk("ovf.sticky", 32'(ovf_sticky), 1);
        chk("ovf.level", 32'(level), 256);
        chk("ovf.head", 32'(m_data), 32'(exp_head));

        // Full with simultaneous push and pop: no drops, order kept
        for (int k = 0; k < 10; k++) begin
            s_valid = 1; s_data = DW'(12'h200 + k); s_ch = CW'(k); m_ready = 1;
            chk($sformatf("pt%0d.m_data", k), 32'(m_data), 32'(q[0][DW-1:0]));
            chk($sformatf("pt%0d.m_ch", k), 32'(m_ch), 32'(q[0][DW+CW-1:DW]));
            step();
            void'(q.pop_front());
            q.push_back({s_ch, s_data});
            chk($sformatf("pt%0d.level", k), 32'(level), 256);
        end
        chk("pt.cnt", 32'(ovf_cnt), 4);

        // Drain a few, then async reset mid-drain
        s_valid = 0; m_ready = 1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("dr%0d.m_data", k), 32'(m_data), 32'(q[0][DW-1:0]));
            step();
            void'(q.pop_front());
        end
        chk("dr.level", 32'(level), 251);
        rst_n = 0;
        #2;
        chk("arst.level", 32'(level), 0);
        chk("arst.empty", 32'(empty), 1);
        chk("arst.m_valid", 32'(m_valid), 0);
        chk("arst.full", 32'(full), 0);
        chk("arst.ae", 32'(almost_empty), 1);
        chk("arst.af", 32'(almost_full), 0);
        chk("arst.sticky", 32'(ovf_sticky), 0);
        chk("arst.cnt", 32'(ovf_cnt), 0);
        idle();
        #2;
        rst_n = 1;

        // Counter saturation and clear-with-drop
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one(DW'(i), CW'(i));
        for (int k = 0; k < 20; k++) push_one(12'hF00, 2'd3);
        chk("sat.cnt", 32'(ovf_cnt), 15);
        chk("sat.sticky", 32'(ovf_sticky), 1);
        ovf_clr = 1; s_valid = 1; s_data = 12'hF01;
        step();
        chk("clrdrop.cnt", 32'(ovf_cnt), 1);
        chk("clrdrop.sticky", 32'(ovf_sticky), 1);
        s_valid = 0;
        step();
        chk("clr.cnt", 32'(ovf_cnt), 0);
        chk("clr.sticky", 32'(ovf_sticky), 0);
        idle();

        // Flush at level 100 with a push pending
        do_reset();
        for (int i = 0; i < 100; i++) push_one(DW'(i), CW'(i));
        chk("fl.pre.level", 32'(level), 100);
        flush = 1; s_valid = 1; s_data = 12'h777; s_ch = 2'd2; m_ready = 1;
        step();
        chk("fl.level", 32'(level), 0);
        chk("fl.empty", 32'(empty), 1);
        chk("fl.m_valid", 32'(m_valid), 0);
        chk("fl.ae", 32'(almost_empty), 1);
        idle();
        step();
        chk("fl.post.level", 32'(level), 0);
        push_one(12'h123, 2'd1);
        chk("fl.push.level", 32'(level), 1);
        chk("fl.push.m_data", 32'(m_data), 32'h123);
        chk("fl.push.m_ch", 32'(m_ch), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
